// File: rtl/usb_in_fifo_retry.sv
// usb_in_fifo_retry
// Multi-packet circular IN-endpoint buffer between the application byte
// stream and the SIE. The SIE reads speculatively through rd_q; an ACK
// commits the bytes of the current packet (frees space) and a rollback
// rewinds rd_q to the last committed position for retransmission.
// The application side runs every clk_i cycle; SIE actions only count on
// cycles with clk_gate_i high.
//
// Optional feature macro: IN_FIFO_FLUSH_EN
//   defined   -> app_in_flush_i port exists; a high level at a clk_i edge
//                clears all pointers and counters (highest priority,
//                a simultaneous write is dropped).
//   undefined -> no flush port; state is cleared only by reset_n_i.

module usb_in_fifo_retry #(
  parameter int IN_BUFFER_SIZE     = 64,
  parameter int IN_MAX_PACKET_SIZE = 8,
  localparam int PW = $clog2(IN_BUFFER_SIZE),
  localparam int CW = $clog2(IN_BUFFER_SIZE + 1),
  localparam int KW = $clog2(IN_MAX_PACKET_SIZE + 1)
) (
  input  logic          clk_i,
  input  logic          reset_n_i,
  input  logic          clk_gate_i,
`ifdef IN_FIFO_FLUSH_EN
  input  logic          app_in_flush_i,
`endif
  input  logic [7:0]    app_in_data_i,
  input  logic          app_in_valid_i,
  output logic          app_in_ready_o,
  output logic [7:0]    in_data_o,
  output logic          in_valid_o,
  input  logic          in_consume_i,
  input  logic          in_ack_i,
  input  logic          in_rollback_i,
  output logic [KW-1:0] in_pkt_cnt_o,
  output logic [CW-1:0] in_level_o,
  output logic          app_in_buffer_empty_o
);

  // Byte storage and buffer state
  logic [7:0]    mem [IN_BUFFER_SIZE];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [PW-1:0] rd_commit_q;
  logic [CW-1:0] occ_q;
  logic [KW-1:0] pkt_q;
  logic          ready_q;

  // Next-state values and decoded actions
  logic [PW-1:0] wr_next;
  logic [PW-1:0] rd_next;
  logic [PW-1:0] rd_commit_next;
  logic [CW-1:0] occ_next;
  logic [KW-1:0] pkt_next;
  logic [CW-1:0] unread;
  logic          flush;
  logic          valid;
  logic          wr_en;
  logic          rollback_en;
  logic          ack_en;
  logic          consume_en;

  // Advance a buffer pointer, wrapping from the last slot back to 0 so
  // non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    logic [PW-1:0] r;
    if (p == PW'(IN_BUFFER_SIZE - 1)) begin
      r = {PW{1'b0}};
    end else begin
      r = p + {{(PW-1){1'b0}}, 1'b1};
    end
    return r;
  endfunction

`ifdef IN_FIFO_FLUSH_EN
  assign flush = app_in_flush_i;
`else
  assign flush = 1'b0;
`endif

  // Decode which SIE action wins this cycle (rollback > ack > consume)
  // and whether the application write is accepted.
  always_comb begin
    unread      = occ_q - CW'(pkt_q);
    valid       = (unread != {CW{1'b0}}) && (pkt_q < KW'(IN_MAX_PACKET_SIZE));
    wr_en       = app_in_valid_i & ready_q & ~flush;
    rollback_en = clk_gate_i & in_rollback_i & ~flush;
    ack_en      = clk_gate_i & ~in_rollback_i & in_ack_i & ~flush;
    consume_en  = clk_gate_i & ~in_rollback_i & ~in_ack_i & in_consume_i & valid & ~flush;
  end

  // Compute next pointers and counters from the decoded actions; a write
  // may coincide with any SIE action, so occupancy combines both.
  always_comb begin
    wr_next        = wr_q;
    rd_next        = rd_q;
    rd_commit_next = rd_commit_q;
    occ_next       = occ_q;
    pkt_next       = pkt_q;
    if (flush) begin
      wr_next        = {PW{1'b0}};
      rd_next        = {PW{1'b0}};
      rd_commit_next = {PW{1'b0}};
      occ_next       = {CW{1'b0}};
      pkt_next       = {KW{1'b0}};
    end else begin
      if (rollback_en) begin
        rd_next  = rd_commit_q;
        pkt_next = {KW{1'b0}};
      end else if (ack_en) begin
        rd_commit_next = rd_q;
        occ_next       = occ_q - CW'(pkt_q);
        pkt_next       = {KW{1'b0}};
      end else if (consume_en) begin
        rd_next  = ptr_inc(rd_q);
        pkt_next = pkt_q + {{(KW-1){1'b0}}, 1'b1};
      end else begin
        rd_next  = rd_q;
        pkt_next = pkt_q;
      end
      if (wr_en) begin
        wr_next  = ptr_inc(wr_q);
        occ_next = occ_next + {{(CW-1){1'b0}}, 1'b1};
      end else begin
        wr_next  = wr_q;
      end
    end
  end

  // Pointer/counter registers; ready is registered from the next occupancy
  // so the buffer can never be written past full.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_q        <= {PW{1'b0}};
      rd_q        <= {PW{1'b0}};
      rd_commit_q <= {PW{1'b0}};
      occ_q       <= {CW{1'b0}};
      pkt_q       <= {KW{1'b0}};
      ready_q     <= 1'b0;
    end else begin
      wr_q        <= wr_next;
      rd_q        <= rd_next;
      rd_commit_q <= rd_commit_next;
      occ_q       <= occ_next;
      pkt_q       <= pkt_next;
      ready_q     <= (occ_next < CW'(IN_BUFFER_SIZE));
    end
  end

  // Storage write port; cleared on reset so in_data_o reads 0 afterwards.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < IN_BUFFER_SIZE; i++) begin
        mem[i] <= 8'h00;
      end
    end else if (wr_en) begin
      mem[wr_q] <= app_in_data_i;
    end
  end

  assign app_in_ready_o        = ready_q;
  assign in_data_o             = mem[rd_q];
  assign in_valid_o            = valid;
  assign in_pkt_cnt_o          = pkt_q;
  assign in_level_o            = occ_q;
  assign app_in_buffer_empty_o = (occ_q == {CW{1'b0}});

endmodule

// File: tb/tb_usb_in_fifo_retry.sv
// Self-checking bench for usb_in_fifo_retry (12-byte buffer, 8-byte packets).
// Reference model: a queue of uncommitted bytes plus a count of bytes read
// in the current packet.

module tb_usb_in_fifo_retry;

  localparam int BUF  = 12;
  localparam int MAXP = 8;
  localparam int CW   = $clog2(BUF + 1);
  localparam int KW   = $clog2(MAXP + 1);

  logic          clk = 1'b0;
  logic          reset_n;
  logic          clk_gate;
  logic          flush;
  logic [7:0]    app_data;
  logic          app_valid;
  logic          app_ready;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_consume;
  logic          in_ack;
  logic          in_rollback;
  logic [KW-1:0] in_pkt_cnt;
  logic [CW-1:0] in_level;
  logic          buf_empty;

  logic [7:0] mq[$];
  int         mpkt;
  bit         mready;
  int         n_cmp  = 0;
  int         n_fail = 0;

  usb_in_fifo_retry #(
    .IN_BUFFER_SIZE(BUF),
    .IN_MAX_PACKET_SIZE(MAXP)
  ) dut (
    .clk_i(clk),
    .reset_n_i(reset_n),
    .clk_gate_i(clk_gate),
`ifdef IN_FIFO_FLUSH_EN
    .app_in_flush_i(flush),
`endif
    .app_in_data_i(app_data),
    .app_in_valid_i(app_valid),
    .app_in_ready_o(app_ready),
    .in_data_o(in_data),
    .in_valid_o(in_valid),
    .in_consume_i(in_consume),
    .in_ack_i(in_ack),
    .in_rollback_i(in_rollback),
    .in_pkt_cnt_o(in_pkt_cnt),
    .in_level_o(in_level),
    .app_in_buffer_empty_o(buf_empty)
  );

  always #5 clk = ~clk;

  function automatic bit m_valid();
    return ((mq.size() - mpkt) > 0) && (mpkt < MAXP);
  endfunction

  function automatic logic [7:0] m_data();
    if (mpkt < mq.size()) return mq[mpkt];
    return 8'h00;
  endfunction

  // Drive one cycle of inputs, advance the model, step past the edge.
  task automatic tick(input bit v, input logic [7:0] d, input bit g,
                      input bit c, input bit a, input bit r, input bit f);
    bit mv;
    bit wr;
    app_valid = v; app_data = d; clk_gate = g;
    in_consume = c; in_ack = a; in_rollback = r; flush = f;
    mv = m_valid();
    wr = v && mready;
    if (f) begin
      mq.delete();
      mpkt = 0;
    end else begin
      if (g && r) mpkt = 0;
      else if (g && a) begin
        repeat (mpkt) void'(mq.pop_front());
        mpkt = 0;
      end else if (g && c && mv) mpkt++;
      if (wr) mq.push_back(d);
    end
    mready = (mq.size() < BUF);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    app_valid = 1'b0; app_data = 8'h00; clk_gate = 1'b0;
    in_consume = 1'b0; in_ack = 1'b0; in_rollback = 1'b0; flush = 1'b0;
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mq.delete(); mpkt = 0; mready = 1'b0;
    n_cmp++; if (app_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", app_ready); end
    n_cmp++; if (in_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", in_valid); end
    n_cmp++; if (in_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", in_data); end
    n_cmp++; if (in_pkt_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_pkt: got %0d want 0", in_pkt_cnt); end
    n_cmp++; if (in_level !== 4'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", in_level); end
    n_cmp++; if (buf_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", buf_empty); end
    reset_n = 1'b1;
    tick(0, 8'h00, 0, 0, 0, 0, 0);
    n_cmp++; if (app_ready !== 1'b1) begin n_fail++; $display("FAIL ready_rise: got %b want 1", app_ready); end
  endtask

  task automatic test_write_basic();
    for (int i = 0; i < 8; i++) tick(1, 8'h11 + 8'(i), 1, 0, 0, 0, 0);
    n_cmp++; if (in_level !== 4'd8) begin n_fail++; $display("FAIL wr_level: got %0d want 8", in_level); end
    n_cmp++; if (in_valid !== 1'b1) begin n_fail++; $display("FAIL wr_valid: got %b want 1", in_valid); end
    n_cmp++; if (in_data !== 8'h11) begin n_fail++; $display("FAIL wr_data: got %h want 11", in_data); end
    n_cmp++; if (buf_empty !== 1'b0) begin n_fail++; $display("FAIL wr_empty: got %b want 0", buf_empty); end
  endtask

  task automatic test_packet_limit();
    tick(1, 8'h19, 1, 0, 0, 0, 0);
    tick(1, 8'h1A, 1, 0, 0, 0, 0);
    repeat (9) tick(0, 8'h00, 1, 1, 0, 0, 0);
    n_cmp++; if (in_pkt_cnt !== 4'd8) begin n_fail++; $display("FAIL lim_pkt: got %0d want 8", in_pkt_cnt); end
    n_cmp++; if (in_valid !== 1'b0) begin n_fail++; $display("FAIL lim_valid: got %b want 0", in_valid); end
    n_cmp++; if (in_level !== 4'd10) begin n_fail++; $display("FAIL lim_level: got %0d want 10", in_level); end
    tick(0, 8'h00, 1, 0, 1, 0, 0);
    n_cmp++; if (in_level !== 4'd2) begin n_fail++; $display("FAIL ack_level: got %0d want 2", in_level); end
    n_cmp++; if (in_data !== 8'h19) begin n_fail++; $display("FAIL ack_data: got %h want 19", in_data); end
    n_cmp++; if (in_pkt_cnt !== 4'd0) begin n_fail++; $display("FAIL ack_pkt: got %0d want 0", in_pkt_cnt); end
  endtask

  task automatic test_rollback();
    for (int i = 0; i < 6; i++) tick(1, 8'h21 + 8'(i), 1, 0, 0, 0, 0);
    repeat (5) tick(0, 8'h00, 1, 1, 0, 0, 0);
    n_cmp++; if (in_pkt_cnt !== 4'd5) begin n_fail++; $display("FAIL rb_pre_pkt: got %0d want 5", in_pkt_cnt); end
    n_cmp++; if (in_data !== 8'h24) begin n_fail++; $display("FAIL rb_pre_data: got %h want 24", in_data); end
    tick(0, 8'h00, 1, 0, 0, 1, 0);
    n_cmp++; if (in_pkt_cnt !== 4'd0) begin n_fail++; $display("FAIL rb_pkt: got %0d want 0", in_pkt_cnt); end
    n_cmp++; if (in_data !== 8'h19) begin n_fail++; $display("FAIL rb_data: got %h want 19", in_data); end
    n_cmp++; if (in_level !== 4'd8) begin n_fail++; $display("FAIL rb_level: got %0d want 8", in_level); end
    repeat (5) tick(0, 8'h00, 1, 1, 0, 0, 0);
    tick(0, 8'h00, 1, 0, 1, 0, 0);
    n_cmp++; if (in_level !== 4'd3) begin n_fail++; $display("FAIL rb_ack_level: got %0d want 3", in_level); end
    n_cmp++; if (in_data !== 8'h24) begin n_fail++; $display("FAIL rb_ack_data: got %h want 24", in_data); end
  endtask

  task automatic test_full_wrap();
    for (int i = 0; i < 10; i++) tick(1, 8'h30 + 8'(i), 1, 0, 0, 0, 0);
    n_cmp++; if (app_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b want 0", app_ready); end
    n_cmp++; if (in_level !== 4'd12) begin n_fail++; $display("FAIL full_level: got %0d want 12", in_level); end
    repeat (3) tick(0, 8'h00, 1, 1, 0, 0, 0);
    tick(0, 8'h00, 1, 0, 0, 1, 0);
    n_cmp++; if (app_ready !== 1'b0) begin n_fail++; $display("FAIL full_rb_ready: got %b want 0", app_ready); end
    repeat (8) tick(0, 8'h00, 1, 1, 0, 0, 0);
    tick(0, 8'h00, 1, 0, 1, 0, 0);
    n_cmp++; if (app_ready !== 1'b1) begin n_fail++; $display("FAIL full_ack_ready: got %b want 1", app_ready); end
    n_cmp++; if (in_level !== 4'd4) begin n_fail++; $display("FAIL full_ack_level: got %0d want 4", in_level); end
    for (int i = 0; i < 6; i++) tick(1, 8'h50 + 8'(i), 1, 0, 0, 0, 0);
    n_cmp++; if (in_level !== 4'd10) begin n_fail++; $display("FAIL wrap_level: got %0d want 10", in_level); end
    for (int k = 0; k < 30 && mq.size() > 0; k++) begin
      if (m_valid()) begin
        n_cmp++;
        if (in_data !== m_data()) begin n_fail++; $display("FAIL wrap_data: got %h want %h", in_data, m_data()); end
        tick(0, 8'h00, 1, 1, 0, 0, 0);
      end else begin
        tick(0, 8'h00, 1, 0, 1, 0, 0);
      end
    end
    n_cmp++; if (buf_empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b want 1", buf_empty); end
  endtask

  task automatic test_priority();
    for (int i = 0; i < 4; i++) tick(1, 8'h60 + 8'(i), 1, 0, 0, 0, 0);
    repeat (2) tick(0, 8'h00, 1, 1, 0, 0, 0);
    tick(0, 8'h00, 0, 1, 1, 1, 0);
    n_cmp++; if (in_pkt_cnt !== 4'd2) begin n_fail++; $display("FAIL gate0_pkt: got %0d want 2", in_pkt_cnt); end
    n_cmp++; if (in_level !== 4'd4) begin n_fail++; $display("FAIL gate0_level: got %0d want 4", in_level); end
    tick(0, 8'h00, 1, 1, 1, 1, 0);
    n_cmp++; if (in_pkt_cnt !== 4'd0) begin n_fail++; $display("FAIL prio_pkt: got %0d want 0", in_pkt_cnt); end
    n_cmp++; if (in_level !== 4'd4) begin n_fail++; $display("FAIL prio_level: got %0d want 4", in_level); end
    n_cmp++; if (in_data !== 8'h60) begin n_fail++; $display("FAIL prio_data: got %h want 60", in_data); end
    repeat (2) tick(0, 8'h00, 1, 1, 0, 0, 0);
    tick(0, 8'h00, 1, 1, 1, 0, 0);
    n_cmp++; if (in_level !== 4'd2) begin n_fail++; $display("FAIL ackc_level: got %0d want 2", in_level); end
    n_cmp++; if (in_data !== 8'h62) begin n_fail++; $display("FAIL ackc_data: got %h want 62", in_data); end
    tick(0, 8'h00, 1, 0, 1, 0, 0);
    n_cmp++; if (in_level !== 4'd2) begin n_fail++; $display("FAIL zlp_level: got %0d want 2", in_level); end
    n_cmp++; if (in_data !== 8'h62) begin n_fail++; $display("FAIL zlp_data: got %h want 62", in_data); end
  endtask

`ifdef IN_FIFO_FLUSH_EN
  task automatic test_flush();
    tick(0, 8'h00, 1, 1, 0, 0, 0);
    tick(1, 8'h77, 1, 0, 0, 0, 1);
    n_cmp++; if (in_level !== 4'd0) begin n_fail++; $display("FAIL flush_level: got %0d want 0", in_level); end
    n_cmp++; if (in_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", in_valid); end
    n_cmp++; if (in_pkt_cnt !== 4'd0) begin n_fail++; $display("FAIL flush_pkt: got %0d want 0", in_pkt_cnt); end
    tick(1, 8'h78, 1, 0, 0, 0, 0);
    n_cmp++; if (in_data !== 8'h78) begin n_fail++; $display("FAIL flush_wr_data: got %h want 78", in_data); end
    n_cmp++; if (in_level !== 4'd1) begin n_fail++; $display("FAIL flush_wr_level: got %0d want 1", in_level); end
  endtask
`endif

  task automatic test_random();
    logic [CW-1:0] e_level;
    logic [KW-1:0] e_pkt;
    bit            v, g, c, a, r, f;
    for (int n = 0; n < 600; n++) begin
      v = ($urandom_range(0, 99) < 70);
      g = ($urandom_range(0, 99) < 75);
      c = ($urandom_range(0, 99) < 60);
      a = ($urandom_range(0, 99) < 10);
      r = ($urandom_range(0, 99) < 5);
      f = 1'b0;
`ifdef IN_FIFO_FLUSH_EN
      f = ($urandom_range(0, 99) < 2);
`endif
      tick(v, 8'($urandom), g, c, a, r, f);
      e_level = CW'(mq.size());
      e_pkt   = KW'(mpkt);
      n_cmp++; if (in_level !== e_level) begin n_fail++; $display("FAIL rnd_level @%0d: got %0d want %0d", n, in_level, e_level); end
      n_cmp++; if (in_pkt_cnt !== e_pkt) begin n_fail++; $display("FAIL rnd_pkt @%0d: got %0d want %0d", n, in_pkt_cnt, e_pkt); end
      n_cmp++; if (app_ready !== mready) begin n_fail++; $display("FAIL rnd_ready @%0d: got %b want %b", n, app_ready, mready); end
      n_cmp++; if (in_valid !== m_valid()) begin n_fail++; $display("FAIL rnd_valid @%0d: got %b want %b", n, in_valid, m_valid()); end
      n_cmp++; if (buf_empty !== (mq.size() == 0)) begin n_fail++; $display("FAIL rnd_empty @%0d: got %b", n, buf_empty); end
      if (m_valid()) begin
        n_cmp++; if (in_data !== m_data()) begin n_fail++; $display("FAIL rnd_data @%0d: got %h want %h", n, in_data, m_data()); end
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    for (int i = 0; i < 3; i++) tick(1, 8'hA0 + 8'(i), 1, 0, 0, 0, 0);
    repeat (2) tick(0, 8'h00, 1, 1, 0, 0, 0);
    reset_n = 1'b0;
    #1;
    mq.delete(); mpkt = 0; mready = 1'b0;
    n_cmp++; if (app_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ready: got %b want 0", app_ready); end
    n_cmp++; if (in_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b want 0", in_valid); end
    n_cmp++; if (in_data !== 8'h00) begin n_fail++; $display("FAIL mid_rst_data: got %h want 00", in_data); end
    n_cmp++; if (in_pkt_cnt !== 4'd0) begin n_fail++; $display("FAIL mid_rst_pkt: got %0d want 0", in_pkt_cnt); end
    n_cmp++; if (in_level !== 4'd0) begin n_fail++; $display("FAIL mid_rst_level: got %0d want 0", in_level); end
    n_cmp++; if (buf_empty !== 1'b1) begin n_fail++; $display("FAIL mid_rst_empty: got %b want 1", buf_empty); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    tick(0, 8'h00, 0, 0, 0, 0, 0);
    n_cmp++; if (app_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_ready_rise: got %b want 1", app_ready); end
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_packet_limit();
    test_rollback();
    test_full_wrap();
    test_priority();
`ifdef IN_FIFO_FLUSH_EN
    test_flush();
`endif
    test_random();
    test_reset_mid_packet();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
